gray_codec: RTL and testbench
=============================

Name: gray_codec

Overview:
- Registered, parameterisable binary/Gray-code converter with independent encode (binary->Gray) and decode (Gray->binary) channels.
- Includes a step monitor that flags any encoder output transition changing more than one bit.
- Used at clock-domain-crossing pointer boundaries, e.g. FIFO pointers, where single-bit-change counters are required.

Parameters:
- N, 4, data width in bits; legal range N >= 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- enc_valid_i  in  1  encoder input qualifier.
- enc_bin_i  in  N  binary value to encode.
- enc_valid_o  out  1  encoder output qualifier.
- enc_gray_o  out  N  Gray-coded result.
- dec_valid_i  in  1  decoder input qualifier.
- dec_gray_i  in  N  Gray value to decode.
- dec_valid_o  out  1  decoder output qualifier.
- dec_bin_o  out  N  binary result.
- step_err_o  out  1  one-cycle pulse on a multi-bit encoder output change.

Behaviour:
- Reset: while rst_i is high, all outputs and internal registers are 0, asynchronously. Assertion mid-operation discards in-flight data. The first valid after release is processed normally.
- Encode function: gray = bin XOR (bin >> 1), i.e. gray[N-1] = bin[N-1] and gray[i] = bin[i+1] ^ bin[i].
- Decode function: bin[N-1] = gray[N-1] and bin[i] = bin[i+1] ^ gray[i], for i from N-2 down to 0 (prefix XOR from the MSB).
- N = 1: both functions are identity.
- Latency: exactly 1 cycle per channel.
  - enc_valid_i at edge k gives enc_valid_o = 1 and enc_gray_o = f(enc_bin_i) after edge k.
  - The decoder channel behaves the same way.
- Valid low: enc_valid_o/dec_valid_o drop to 0 after the edge. enc_gray_o/dec_bin_o hold their last value; data registers are not cleared.
- Channel independence: encoder and decoder are fully independent. Both may accept in the same cycle with no interaction. No backpressure, no ready signals.
- Round-trip: for every x in 0..2^N-1, decoding the encoding of x yields x exactly.
- Wrap-around: encoding 2^N-1 gives 1 followed by N-1 zeros. The step from 2^N-1 to 0 changes exactly one bit.
- Step monitor:
  - Holds a prev_gray register, reset to 0, updated with each new encoder result.
  - On each encoder accept, computes the popcount of (new_gray XOR prev_gray).
  - If the popcount is > 1, step_err_o = 1 in the same cycle enc_valid_o rises; otherwise 0.
  - step_err_o is a single-cycle pulse, never sticky.
  - Repeating the same value (popcount 0) is legal.
  - The first accept after reset compares against 0.

Decomposition:
- Package gray_codec_pkg holds the pure functions bin2gray(N) and gray2bin(N) plus a popcount helper. Functions are width-generic via the parameter or a max-width constant with masking.
- One sub-module is natural: gray_step_monitor. It holds prev_gray, the XOR, popcount and compare logic, and drives step_err_o.
- The conversion datapaths stay inline in gray_codec.

Test Plan (N=4):
- Encode bin 5 (0101) with enc_valid_i=1 -> next cycle enc_valid_o=1, enc_gray_o=7 (0111). Encode 15 -> 8 (1000).
- Decode gray 7 -> next cycle dec_bin_o=5. Decode 8 -> 15. Decode 0 -> 0.
- Count up: enc_bin_i = 0..15 twice on consecutive cycles, including the 15->0 wrap.
  - Required: every enc_gray_o decodes back to its input via the decoder channel fed with the encoder output.
  - Required: step_err_o stays 0 throughout.
- Count down: enc_bin_i = 3, 2, 1, 0, 15, 14, ... -> step_err_o stays 0, and every round-trip equals the input.
- Jump: encode 0, then 5 (gray 0000->0111, 3 bits) -> step_err_o pulses 1 for exactly one cycle with enc_gray_o=7. Then encode 5 again -> step_err_o=0.
- Reset mid-stream: assert rst_i asynchronously between edges while both channels are valid -> all outputs 0 immediately. After release, encode 1 -> enc_gray_o=1, step_err_o=0.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg: width-generic Gray-code helpers shared by gray_codec and its step monitor.
// Each function works on a MAX_W-bit word. Callers zero-extend an N-bit value
// (N <= MAX_W) into the word, and read back the low N bits of the result.
package gray_codec_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // Binary to Gray. Zero upper bits leave the low N bits exact, so N = 1 is the identity.
  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down. Zero upper bits stay zero.
  function automatic word_t gray2bin(input word_t gray);
    word_t bin;
    bin = '0;
    bin[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Number of set bits in the word.
  function automatic int unsigned popcount(input word_t x);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + 32'(x[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_codec_step.sv
// gray_step_monitor: flags any encoder result that differs from the previous
// encoder result in more than one bit.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   accept_i     : encoder accepts a new value this cycle
//   gray_i       : combinational Gray result being registered this cycle
//   step_err_o   : registered single-cycle pulse, aligned with the encoder output valid
module gray_step_monitor
  import gray_codec_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         accept_i,
  input  logic [N-1:0] gray_i,
  output logic         step_err_o
);

  logic [N-1:0] prev_gray;
  logic         multi_bit_c;

  // Hamming distance between the new encoder result and the last one.
  always_comb begin
    multi_bit_c = popcount(word_t'(gray_i ^ prev_gray)) > 32'd1;
  end

  // prev_gray follows accepted results only. The error clears on any cycle without a bad accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_gray  <= '0;
      step_err_o <= 1'b0;
    end else begin
      step_err_o <= accept_i & multi_bit_c;
      if (accept_i) begin
        prev_gray <= gray_i;
      end
    end
  end

endmodule

// File: rtl/gray_codec.sv
// gray_codec: registered binary<->Gray converter with independent encode and
// decode channels, each with a latency of 1 cycle, plus a multi-bit step monitor on the encoder.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   enc_valid_i / enc_bin_i   : encoder input qualifier / binary value
//   enc_valid_o / enc_gray_o  : encoder output qualifier / Gray result (held while idle)
//   dec_valid_i / dec_gray_i  : decoder input qualifier / Gray value
//   dec_valid_o / dec_bin_o   : decoder output qualifier / binary result (held while idle)
//   step_err_o                : pulse when an encoder result changes more than one bit
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enc_valid_i,
  input  logic [N-1:0] enc_bin_i,
  output logic         enc_valid_o,
  output logic [N-1:0] enc_gray_o,
  input  logic         dec_valid_i,
  input  logic [N-1:0] dec_gray_i,
  output logic         dec_valid_o,
  output logic [N-1:0] dec_bin_o,
  output logic         step_err_o
);

  logic [N-1:0] enc_gray_c;
  logic [N-1:0] dec_bin_c;

  // Conversion datapaths. Zero-extend the input, then keep the low N bits.
  always_comb begin
    enc_gray_c = N'(bin2gray(word_t'(enc_bin_i)));
    dec_bin_c  = N'(gray2bin(word_t'(dec_gray_i)));
  end

  // Encoder channel. The data register holds its value when the input is not valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_valid_o <= 1'b0;
      enc_gray_o  <= '0;
    end else begin
      enc_valid_o <= enc_valid_i;
      if (enc_valid_i) begin
        enc_gray_o <= enc_gray_c;
      end
    end
  end

  // Decoder channel, fully independent of the encoder.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_valid_o <= 1'b0;
      dec_bin_o   <= '0;
    end else begin
      dec_valid_o <= dec_valid_i;
      if (dec_valid_i) begin
        dec_bin_o <= dec_bin_c;
      end
    end
  end

  gray_step_monitor #(
    .N (N)
  ) u_step (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .accept_i   (enc_valid_i),
    .gray_i     (enc_gray_c),
    .step_err_o (step_err_o)
  );

endmodule

// File: tb/tb_gray_codec.sv
// tb_gray_codec: directed and random checks of gray_codec (N = 4) against a
// table-based reference model.
module tb_gray_codec;

  localparam int unsigned N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enc_valid_i;
  logic [N-1:0] enc_bin_i;
  logic         enc_valid_o;
  logic [N-1:0] enc_gray_o;
  logic         dec_valid_i;
  logic [N-1:0] dec_gray_i;
  logic         dec_valid_o;
  logic [N-1:0] dec_bin_o;
  logic         step_err_o;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic         m_enc_valid;
  logic [N-1:0] m_enc_gray;
  logic         m_dec_valid;
  logic [N-1:0] m_dec_bin;
  logic [N-1:0] m_prev;
  logic         m_err;

  gray_codec #(.N(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enc_valid_i (enc_valid_i),
    .enc_bin_i   (enc_bin_i),
    .enc_valid_o (enc_valid_o),
    .enc_gray_o  (enc_gray_o),
    .dec_valid_i (dec_valid_i),
    .dec_gray_i  (dec_gray_i),
    .dec_valid_o (dec_valid_o),
    .dec_bin_o   (dec_bin_o),
    .step_err_o  (step_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Gray code of x.
  function automatic logic [N-1:0] m_enc(input int x);
    return N'(x ^ (x >> 1));
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic logic [N-1:0] m_dec(input logic [N-1:0] g);
    for (int b = 0; b < (1 << N); b++) begin
      if (m_enc(b) == g) return N'(b);
    end
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_enc_valid = 1'b0;
    m_enc_gray  = '0;
    m_dec_valid = 1'b0;
    m_dec_bin   = '0;
    m_prev      = '0;
    m_err       = 1'b0;
  endtask

  // Drive one cycle, advance the model, and compare every output.
  task automatic cycle(input logic ev, input logic [N-1:0] eb,
                       input logic dv, input logic [N-1:0] dg);
    enc_valid_i = ev;
    enc_bin_i   = eb;
    dec_valid_i = dv;
    dec_gray_i  = dg;
    @(posedge clk_i);
    #1;
    m_err = ev && ($countones(m_enc(int'(eb)) ^ m_prev) > 1);
    if (ev) begin
      m_enc_gray = m_enc(int'(eb));
      m_prev     = m_enc_gray;
    end
    m_enc_valid = ev;
    if (dv) m_dec_bin = m_dec(dg);
    m_dec_valid = dv;
    check("enc_valid", 32'(enc_valid_o), 32'(m_enc_valid));
    check("enc_gray",  32'(enc_gray_o),  32'(m_enc_gray));
    check("dec_valid", 32'(dec_valid_o), 32'(m_dec_valid));
    check("dec_bin",   32'(dec_bin_o),   32'(m_dec_bin));
    check("step_err",  32'(step_err_o),  32'(m_err));
  endtask

  initial begin
    logic [N-1:0] hist [$];
    logic [N-1:0] v;

    rst_i = 1'b1;
    enc_valid_i = 1'b0;
    enc_bin_i = '0;
    dec_valid_i = 1'b0;
    dec_gray_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_enc_valid", 32'(enc_valid_o), 32'd0);
    check("rst_enc_gray",  32'(enc_gray_o),  32'd0);
    check("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    check("rst_dec_bin",   32'(dec_bin_o),   32'd0);
    check("rst_step_err",  32'(step_err_o),  32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Known vectors.
    cycle(1'b1, 4'd5, 1'b1, 4'd7);
    check("enc5", 32'(enc_gray_o), 32'd7);
    check("dec7", 32'(dec_bin_o), 32'd5);
    cycle(1'b1, 4'd15, 1'b1, 4'd8);
    check("enc15", 32'(enc_gray_o), 32'd8);
    check("dec8", 32'(dec_bin_o), 32'd15);
    cycle(1'b0, 4'd0, 1'b1, 4'd0);
    check("dec0", 32'(dec_bin_o), 32'd0);
    check("enc_hold", 32'(enc_gray_o), 32'd8);

    // Count up twice through the 15->0 wrap, with the decoder fed from the encoder output.
    hist.delete();
    for (int i = 0; i < 32; i++) begin
      v = N'(i % 16);
      cycle(1'b1, v, enc_valid_o, enc_gray_o);
      check("up_step_err", 32'(step_err_o), 32'd0);
      if (i >= 1) check("up_roundtrip", 32'(dec_bin_o), 32'(hist[i-1]));
      hist.push_back(v);
    end

    // Walk up to 4 so the count-down begins one step away.
    for (int i = 0; i < 5; i++) cycle(1'b1, N'(i), 1'b0, '0);

    // Count down 3, 2, 1, 0, 15, ...
    hist.delete();
    for (int i = 0; i < 32; i++) begin
      v = N'((3 - i + 32) % 16);
      cycle(1'b1, v, enc_valid_o, enc_gray_o);
      check("dn_step_err", 32'(step_err_o), 32'd0);
      if (i >= 1) check("dn_roundtrip", 32'(dec_bin_o), 32'(hist[i-1]));
      hist.push_back(v);
    end

    // Jump from 0 to 5 is a 3-bit change.
    cycle(1'b1, 4'd0, 1'b0, '0);
    cycle(1'b1, 4'd5, 1'b0, '0);
    check("jump_err", 32'(step_err_o), 32'd1);
    check("jump_gray", 32'(enc_gray_o), 32'd7);
    cycle(1'b0, 4'd0, 1'b0, '0);
    check("jump_pulse", 32'(step_err_o), 32'd0);
    cycle(1'b1, 4'd5, 1'b0, '0);
    check("repeat_err", 32'(step_err_o), 32'd0);

    // Random traffic on both channels.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom), N'($urandom), 1'($urandom), N'($urandom));
    end

    // Reset asserted between edges while both channels are valid.
    cycle(1'b1, N'($urandom), 1'b1, N'($urandom));
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_enc_valid", 32'(enc_valid_o), 32'd0);
    check("mid_rst_enc_gray",  32'(enc_gray_o),  32'd0);
    check("mid_rst_dec_valid", 32'(dec_valid_o), 32'd0);
    check("mid_rst_dec_bin",   32'(dec_bin_o),   32'd0);
    check("mid_rst_step_err",  32'(step_err_o),  32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cycle(1'b1, 4'd1, 1'b0, '0);
    check("post_rst_gray", 32'(enc_gray_o), 32'd1);
    check("post_rst_err", 32'(step_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
